com_io_ctrl: RTL and testbench
==============================

Name: com_io_ctrl

Overview:
Host-side I/O sequencer for the multi-core processor top level. It streams 16-bit words from the host com port into shared data memory and starts the cores. When the cores report completion, it streams a fixed result window back out of memory to the host. It owns the 2-bit top-level `state` and the `output_write_start` / `output_write_done` handshake seen by the host.

Parameters:
- DATA_W, 16, width of com words and memory data
- ADDR_W, 12, data-memory address width
- OUT_BASE, 0, first memory address of the result window
- OUT_LEN, 16, number of result words streamed out (1..2^ADDR_W)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- com_data_in  in  DATA_W  host load word
- data_write_start  in  1  host load session active
- data_write_done  in  1  host: current word is the final load word
- mem_addr  out  ADDR_W  data-memory address
- mem_wdata  out  DATA_W  data-memory write data
- mem_we  out  1  data-memory write enable
- mem_rdata  in  DATA_W  data-memory read data, 1-cycle synchronous read latency
- cores_start  out  1  one-cycle pulse releasing the cores
- cores_done  in  1  level, all cores halted
- state  out  2  0 IDLE, 1 LOAD, 2 RUN, 3 UNLOAD
- com_data_out  out  DATA_W  result word to host
- output_write_start  out  1  com_data_out valid this cycle
- output_write_done  out  1  high with the final output word
- load_overflow  out  1  sticky: load exceeded memory depth

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-high, port `reset`. All outputs are registered.
- Reset values: state=IDLE; all outputs 0; load and unload counters 0; load_overflow=0.
- Reset mid-operation: returns to IDLE next edge. No further mem_we, no pending output, and no cores_start are issued.
- IDLE -> LOAD when data_write_start=1. The word on com_data_in in that same cycle is the first load word.
- LOAD: on every cycle with data_write_start=1 or data_write_done=1:
  - mem_we=1, mem_addr=load_cnt, mem_wdata=com_data_in, then load_cnt++.
  - Write is visible on the bus one cycle after capture.
- LOAD exit: data_write_done=1 marks the final word; it is written, then the block goes to RUN. If start=1 and done=1 together, the word is written once and treated as final.
- LOAD, both inputs low: no write, stay in LOAD (host stall).
- Load overflow: when load_cnt has wrapped past 2^ADDR_W-1, further words are dropped (mem_we=0) and load_overflow is set. The load still finishes normally on done.
- RUN entry: cores_start is a single pulse on the first RUN cycle. RUN -> UNLOAD on the first cycle cores_done=1 is sampled, and never before the cycle after the pulse.
- UNLOAD read side: issue reads at OUT_BASE+i for i=0..OUT_LEN-1, one per cycle. Addresses wrap modulo 2^ADDR_W.
- UNLOAD output side: one cycle after each read, com_data_out=mem_rdata and output_write_start=1.
- Output stream: exactly OUT_LEN consecutive valid cycles with no bubbles. output_write_done=1 only on the last one.
- UNLOAD exit: return to IDLE the cycle after the last word. output_write_start and output_write_done drop to 0; com_data_out holds its last value.
- Input masking: data_write_* are ignored outside IDLE/LOAD, and cores_done is ignored outside RUN.

Optional Feature:
Macro: COM_CHECKSUM_EN.
- Defined: one extra word follows the result window, giving OUT_LEN+1 valid cycles.
  - The extra word is the modulo-2^DATA_W sum of all words actually written during LOAD.
  - output_write_done moves to the checksum cycle.
- Undefined: no accumulator is built and the stream is exactly OUT_LEN words.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with random inputs -> state=0, all outputs 0, no mem_we.
- Basic load: stream words 5,7,9 (done with 9) -> three mem_we at addresses 0,1,2 with data 5,7,9; state 1 -> 2; one cores_start pulse.
- Stall and simultaneous flags: in LOAD drop start for 3 cycles, then assert start=1 and done=1 with word 0xABCD -> no writes during the stall; one write of 0xABCD; enter RUN.
- Unload, OUT_BASE=4 and OUT_LEN=4, memory holding 10..13 at addresses 4..7:
  - Raise cores_done -> com_data_out 10,11,12,13 on four consecutive start cycles.
  - done only with 13; then state=0.
  - With COM_CHECKSUM_EN, a fifth word equal to the load sum follows, and done moves to it.
- Overflow, ADDR_W=2: load 6 words -> only the first 4 written; load_overflow=1 and stays 1 through RUN/UNLOAD until reset.
- Reset mid-UNLOAD after 2 words -> next cycle state=0, output_write_start=0, output_write_done never asserted.

Source files
------------

// File: rtl/com_io_ctrl.sv
// -----------------------------------------------------------------------------
// com_io_ctrl
// Host-side I/O sequencer for the multi-core processor top level.
//   IDLE   : waits for the host to open a load session.
//   LOAD   : writes each host word into data memory at consecutive addresses.
//   RUN    : pulses cores_start once, then waits for cores_done.
//   UNLOAD : reads OUT_LEN words starting at OUT_BASE and streams them back
//            to the host on com_data_out with output_write_start/done.
//
// Optional build macro COM_CHECKSUM_EN: appends one extra output word, the
// modulo-2^DATA_W sum of every word actually written during LOAD, and moves
// output_write_done onto that word.
//
// Ports:
//   clk                 in   system clock
//   reset               in   synchronous, active-high reset
//   com_data_in         in   host load word
//   data_write_start    in   host load session active
//   data_write_done     in   current word is the final load word
//   mem_addr            out  data-memory address
//   mem_wdata           out  data-memory write data
//   mem_we              out  data-memory write enable
//   mem_rdata           in   data-memory read data (1-cycle read latency)
//   cores_start         out  one-cycle pulse releasing the cores
//   cores_done          in   level, all cores halted
//   state               out  0 IDLE, 1 LOAD, 2 RUN, 3 UNLOAD
//   com_data_out        out  result word to host
//   output_write_start  out  com_data_out valid this cycle
//   output_write_done   out  high with the final output word
//   load_overflow       out  sticky: load exceeded memory depth
// All outputs are registered.
// -----------------------------------------------------------------------------
module com_io_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int OUT_BASE = 0,
  parameter int OUT_LEN  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] com_data_in,
  input  logic              data_write_start,
  input  logic              data_write_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cores_start,
  input  logic              cores_done,
  output logic [1:0]        state,
  output logic [DATA_W-1:0] com_data_out,
  output logic              output_write_start,
  output logic              output_write_done,
  output logic              load_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_UNLOAD = 2'd3
  } state_e;

  // Counters carry one extra bit so a full 2^ADDR_W window is representable.
  localparam logic [ADDR_W:0]   C_OUT_LEN  = (ADDR_W+1)'(OUT_LEN);
  localparam logic [ADDR_W:0]   C_LAST_IDX = (ADDR_W+1)'(OUT_LEN - 1);
  localparam logic [ADDR_W-1:0] C_OUT_BASE = ADDR_W'(OUT_BASE);

  state_e              r_state;
  state_e              w_state_nxt;

  logic [ADDR_W:0]     r_load_cnt;
  logic [ADDR_W:0]     w_cnt_cur;
  logic                w_load_word;
  logic                w_load_drop;
  logic                w_load_wr;

  logic [ADDR_W:0]     r_rd_idx;
  logic                w_rd_issue;
  logic                r_rd_pend;   // read address on the bus this cycle
  logic                r_rd_last;   // ... and it is the last one
  logic                r_dv;        // mem_rdata valid this cycle
  logic                r_dv_last;   // ... and it is the last window word

  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_we;
  logic                r_cores_start;
  logic [DATA_W-1:0]   r_com_data_out;
  logic                r_ows;
  logic                r_owd;
  logic                r_load_overflow;

`ifdef COM_CHECKSUM_EN
  logic [DATA_W-1:0]   r_csum;
  logic                r_ck_pend;   // checksum word goes out next
`endif

  // ---------------------------------------------------------------------------
  // Next-state and per-cycle control decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_load_word = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (data_write_start) begin
          w_load_word = 1'b1;
          w_state_nxt = data_write_done ? ST_RUN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (data_write_start || data_write_done) begin
          w_load_word = 1'b1;
          if (data_write_done) w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // The pulse cycle itself never counts as a completion sample.
        if (cores_done && !r_cores_start) w_state_nxt = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        if (r_owd) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A new session restarts addressing at 0 regardless of the stale counter.
  assign w_cnt_cur   = (r_state == ST_IDLE) ? '0 : r_load_cnt;
  assign w_load_drop = w_load_word && w_cnt_cur[ADDR_W];
  assign w_load_wr   = w_load_word && !w_cnt_cur[ADDR_W];

  // First read goes out on the RUN->UNLOAD edge so the stream has no bubble.
  assign w_rd_issue  = ((r_state == ST_RUN) && (w_state_nxt == ST_UNLOAD)) ||
                       ((r_state == ST_UNLOAD) && (r_rd_idx != C_OUT_LEN));

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_load_cnt      <= '0;
      r_rd_idx        <= '0;
      r_rd_pend       <= 1'b0;
      r_rd_last       <= 1'b0;
      r_dv            <= 1'b0;
      r_dv_last       <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_we        <= 1'b0;
      r_cores_start   <= 1'b0;
      r_com_data_out  <= '0;
      r_ows           <= 1'b0;
      r_owd           <= 1'b0;
      r_load_overflow <= 1'b0;
`ifdef COM_CHECKSUM_EN
      r_csum          <= '0;
      r_ck_pend       <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_mem_we      <= w_load_wr;
      r_cores_start <= (w_state_nxt == ST_RUN) && (r_state != ST_RUN);

      // Load side: counter saturates at 2^ADDR_W, after which words drop.
      if (w_load_wr) begin
        r_mem_addr  <= w_cnt_cur[ADDR_W-1:0];
        r_mem_wdata <= com_data_in;
        r_load_cnt  <= w_cnt_cur + 1'b1;
      end else if (w_rd_issue) begin
        r_mem_addr  <= C_OUT_BASE + r_rd_idx[ADDR_W-1:0];
      end
      if (w_load_drop) r_load_overflow <= 1'b1;

`ifdef COM_CHECKSUM_EN
      if (w_load_wr)
        r_csum <= ((r_state == ST_IDLE) ? '0 : r_csum) + com_data_in;
`endif

      // Unload read pipeline: issue -> data valid -> registered output.
      if (w_rd_issue)                r_rd_idx <= r_rd_idx + 1'b1;
      else if (r_state != ST_UNLOAD) r_rd_idx <= '0;
      r_rd_pend <= w_rd_issue;
      r_rd_last <= w_rd_issue && (r_rd_idx == C_LAST_IDX);
      r_dv      <= r_rd_pend;
      r_dv_last <= r_rd_pend && r_rd_last;

`ifdef COM_CHECKSUM_EN
      r_ck_pend <= r_dv && r_dv_last;
      if (r_dv) begin
        r_com_data_out <= mem_rdata;
        r_ows          <= 1'b1;
        r_owd          <= 1'b0;
      end else if (r_ck_pend) begin
        r_com_data_out <= r_csum;
        r_ows          <= 1'b1;
        r_owd          <= 1'b1;
      end else begin
        r_ows          <= 1'b0;
        r_owd          <= 1'b0;
      end
`else
      if (r_dv) begin
        r_com_data_out <= mem_rdata;
        r_ows          <= 1'b1;
        r_owd          <= r_dv_last;
      end else begin
        r_ows          <= 1'b0;
        r_owd          <= 1'b0;
      end
`endif
    end
  end

  assign state              = r_state;
  assign mem_addr           = r_mem_addr;
  assign mem_wdata          = r_mem_wdata;
  assign mem_we             = r_mem_we;
  assign cores_start        = r_cores_start;
  assign com_data_out       = r_com_data_out;
  assign output_write_start = r_ows;
  assign output_write_done  = r_owd;
  assign load_overflow      = r_load_overflow;

endmodule

// File: tb/tb_com_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_com_io_ctrl
// Two instances share the host-side stimulus:
//   dut_a: ADDR_W=12, OUT_BASE=4, OUT_LEN=4 (load/stall/unload behaviour)
//   dut_b: ADDR_W=2,  OUT_BASE=0, OUT_LEN=4 (4-word memory, load overflow)
// Each instance has its own behavioural synchronous-read memory.
// -----------------------------------------------------------------------------
module tb_com_io_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        start;
  logic        done;
  logic        cdone;

  logic [11:0] addr_a;
  logic [15:0] wdata_a, rdata_a, dout_a;
  logic        we_a, cs_a, ows_a, owd_a, ovf_a;
  logic [1:0]  st_a;

  logic [1:0]  addr_b;
  logic [15:0] wdata_b, rdata_b, dout_b;
  logic        we_b, cs_b, ows_b, owd_b, ovf_b;
  logic [1:0]  st_b;

  always #5 clk = ~clk;

  com_io_ctrl #(.DATA_W(16), .ADDR_W(12), .OUT_BASE(4), .OUT_LEN(4)) dut_a (
    .clk(clk), .reset(reset), .com_data_in(din),
    .data_write_start(start), .data_write_done(done),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_we(we_a), .mem_rdata(rdata_a),
    .cores_start(cs_a), .cores_done(cdone), .state(st_a),
    .com_data_out(dout_a), .output_write_start(ows_a),
    .output_write_done(owd_a), .load_overflow(ovf_a)
  );

  com_io_ctrl #(.DATA_W(16), .ADDR_W(2), .OUT_BASE(0), .OUT_LEN(4)) dut_b (
    .clk(clk), .reset(reset), .com_data_in(din),
    .data_write_start(start), .data_write_done(done),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_we(we_b), .mem_rdata(rdata_b),
    .cores_start(cs_b), .cores_done(cdone), .state(st_b),
    .com_data_out(dout_b), .output_write_start(ows_b),
    .output_write_done(owd_b), .load_overflow(ovf_b)
  );

  // Behavioural memories, 1-cycle synchronous read
  logic [15:0] mem_a [0:4095];
  logic [15:0] mem_b [0:3];
  int          wr_cnt_a = 0;
  int          wr_cnt_b = 0;

  initial begin
    for (int i = 0; i < 4096; i++) mem_a[i] = '0;
    for (int i = 0; i < 4; i++)    mem_b[i] = '0;
  end

  always @(posedge clk) begin
    rdata_a <= mem_a[addr_a];
    rdata_b <= mem_b[addr_b];
    if (we_a) begin mem_a[addr_a] <= wdata_a; wr_cnt_a <= wr_cnt_a + 1; end
    if (we_b) begin mem_b[addr_b] <= wdata_b; wr_cnt_b <= wr_cnt_b + 1; end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vector table: inputs applied before an edge, expected dut_a outputs after it
  typedef struct {
    logic        start;
    logic        done;
    logic        cdone;
    logic [15:0] din;
    logic [1:0]  st;
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic        cs;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(logic s, logic d, logic c, logic [15:0] w,
                              logic [1:0] st, logic we, logic [11:0] a,
                              logic [15:0] wd, logic cs);
    vec_t v;
    v.start = s; v.done = d; v.cdone = c; v.din = w;
    v.st = st; v.we = we; v.addr = a; v.wdata = wd; v.cs = cs;
    return v;
  endfunction

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      start = vecs[i].start; done = vecs[i].done;
      cdone = vecs[i].cdone; din  = vecs[i].din;
      tick();
      check($sformatf("v%0d_state", i), st_a, vecs[i].st);
      check($sformatf("v%0d_we", i), we_a, vecs[i].we);
      check($sformatf("v%0d_cs", i), cs_a, vecs[i].cs);
      check($sformatf("v%0d_b_we", i), we_b, vecs[i].we);
      if (vecs[i].we) begin
        check($sformatf("v%0d_addr", i), addr_a, vecs[i].addr);
        check($sformatf("v%0d_wdata", i), wdata_a, vecs[i].wdata);
      end
    end
  endtask

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  task automatic push_ck(input logic [15:0] sa, input logic [15:0] sb);
`ifdef COM_CHECKSUM_EN
    exp_a.push_back(sa);
    exp_b.push_back(sb);
`else
    if (sa === 16'hxxxx || sb === 16'hxxxx) $display("checksum build off");
`endif
  endtask

  // Raise cores_done, wait for the stream, then check it word by word.
  task automatic run_unload(input string tag);
    int wait_cyc = 0;
    int n;
    start = 1'b0; done = 1'b0; cdone = 1'b1;
    while (!ows_a && wait_cyc < 20) begin tick(); wait_cyc++; end
    check({tag, "_stream_seen"}, ows_a, 1'b1);
    if (ows_a) begin
      n = exp_a.size();
      for (int i = 0; i < n; i++) begin
        check($sformatf("%s_w%0d_state", tag, i), st_a, 2'd3);
        check($sformatf("%s_w%0d_ows", tag, i), ows_a, 1'b1);
        check($sformatf("%s_w%0d_owd", tag, i), owd_a, (i == n - 1));
        check($sformatf("%s_w%0d_data", tag, i), dout_a, exp_a[i]);
        check($sformatf("%s_w%0d_b_ows", tag, i), ows_b, 1'b1);
        check($sformatf("%s_w%0d_b_owd", tag, i), owd_b, (i == n - 1));
        check($sformatf("%s_w%0d_b_data", tag, i), dout_b, exp_b[i]);
        cdone = 1'b0;
        tick();
      end
      check({tag, "_end_state"}, st_a, 2'd0);
      check({tag, "_end_ows"}, ows_a, 1'b0);
      check({tag, "_end_owd"}, owd_a, 1'b0);
      check({tag, "_end_hold"}, dout_a, exp_a[n-1]);
      check({tag, "_end_b_state"}, st_b, 2'd0);
    end
    cdone = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_a, base_b;
    int wait_cyc;
    logic bad;
    logic [15:0] w8 [8];

    // S1: basic load 5,7,9 then RUN handshake
    vecs[0]  = mk(1, 0, 0, 16'd5,    2'd1, 1, 12'd0, 16'd5,    0);
    vecs[1]  = mk(1, 0, 0, 16'd7,    2'd1, 1, 12'd1, 16'd7,    0);
    vecs[2]  = mk(0, 1, 0, 16'd9,    2'd2, 1, 12'd2, 16'd9,    1);
    vecs[3]  = mk(0, 0, 0, 16'd0,    2'd2, 0, 12'd0, 16'd0,    0);
    vecs[4]  = mk(0, 0, 1, 16'd0,    2'd3, 0, 12'd0, 16'd0,    0);
    // S2: stall, simultaneous start+done, masked inputs in RUN
    vecs[5]  = mk(1, 0, 0, 16'h1111, 2'd1, 1, 12'd0, 16'h1111, 0);
    vecs[6]  = mk(0, 0, 0, 16'h2222, 2'd1, 0, 12'd0, 16'd0,    0);
    vecs[7]  = mk(0, 0, 0, 16'h3333, 2'd1, 0, 12'd0, 16'd0,    0);
    vecs[8]  = mk(0, 0, 0, 16'h4444, 2'd1, 0, 12'd0, 16'd0,    0);
    vecs[9]  = mk(1, 1, 0, 16'hABCD, 2'd2, 1, 12'd1, 16'hABCD, 1);
    vecs[10] = mk(1, 0, 1, 16'hFFFF, 2'd2, 0, 12'd0, 16'd0,    0);
    vecs[11] = mk(1, 0, 1, 16'hFFFF, 2'd3, 0, 12'd0, 16'd0,    0);

    // Reset with random inputs
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din = 16'($urandom); start = 1'($urandom); done = 1'($urandom);
      cdone = 1'($urandom);
      tick();
    end
    check("rst_state", st_a, 2'd0);
    check("rst_we", we_a, 1'b0);
    check("rst_addr", addr_a, 12'd0);
    check("rst_wdata", wdata_a, 16'd0);
    check("rst_cs", cs_a, 1'b0);
    check("rst_dout", dout_a, 16'd0);
    check("rst_ows", ows_a, 1'b0);
    check("rst_owd", owd_a, 1'b0);
    check("rst_ovf", ovf_a, 1'b0);
    check("rst_b_state", st_b, 2'd0);
    reset = 1'b0; start = 1'b0; done = 1'b0; cdone = 1'b0; din = '0;

    // S1
    apply_rows(0, 4);
    exp_a = '{16'd0, 16'd0, 16'd0, 16'd0};
    exp_b = '{16'd5, 16'd7, 16'd9, 16'd0};
    push_ck(16'd21, 16'd21);
    run_unload("s1");

    // S2
    apply_rows(5, 11);
    exp_a = '{16'd0, 16'd0, 16'd0, 16'd0};
    exp_b = '{16'h1111, 16'hABCD, 16'd9, 16'd0};
    push_ck(16'hBCDE, 16'hBCDE);
    run_unload("s2");

    // S3: fill dut_a window 4..7 with 10..13; dut_b overflows after 4 words
    w8 = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd10, 16'd11, 16'd12, 16'd13};
    for (int i = 0; i < 8; i++) begin
      din = w8[i]; start = (i < 7); done = (i == 7);
      tick();
      check($sformatf("s3_ld%0d_we", i), we_a, 1'b1);
      check($sformatf("s3_ld%0d_addr", i), addr_a, 12'(i));
      check($sformatf("s3_ld%0d_wdata", i), wdata_a, w8[i]);
      check($sformatf("s3_ld%0d_b_we", i), we_b, (i < 4));
    end
    check("s3_state_run", st_a, 2'd2);
    check("s3_ovf_b", ovf_b, 1'b1);
    check("s3_ovf_a", ovf_a, 1'b0);
    exp_a = '{16'd10, 16'd11, 16'd12, 16'd13};
    exp_b = '{16'd1, 16'd2, 16'd3, 16'd4};
    push_ck(16'd56, 16'd10);
    run_unload("s3");
    check("s3_ovf_b_sticky", ovf_b, 1'b1);

    // Reset clears the sticky flag
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_ovf_b", ovf_b, 1'b0);
    check("rst2_state", st_b, 2'd0);

    // S4: 6-word load, overflow sticky through RUN/UNLOAD, reset mid-UNLOAD
    base_a = wr_cnt_a; base_b = wr_cnt_b;
    for (int i = 0; i < 6; i++) begin
      din = 16'(21 + i); start = (i < 5); done = (i == 5);
      tick();
    end
    start = 1'b0; done = 1'b0;
    tick();
    check("s4_wr_a", wr_cnt_a - base_a, 6);
    check("s4_wr_b", wr_cnt_b - base_b, 4);
    check("s4_ovf_b_run", ovf_b, 1'b1);
    check("s4_state_run", st_b, 2'd2);
    cdone = 1'b1;
    wait_cyc = 0;
    while (!ows_a && wait_cyc < 20) begin tick(); wait_cyc++; end
    check("s4_stream_seen", ows_a, 1'b1);
    check("s4_w0_a", dout_a, 16'd25);
    check("s4_w0_b", dout_b, 16'd21);
    check("s4_w0_owd", owd_a, 1'b0);
    check("s4_ovf_b_unload", ovf_b, 1'b1);
    tick();
    check("s4_w1_a", dout_a, 16'd26);
    check("s4_w1_b", dout_b, 16'd22);
    check("s4_w1_owd", owd_a, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0; cdone = 1'b0;
    check("s4_rst_state", st_a, 2'd0);
    check("s4_rst_ows", ows_a, 1'b0);
    check("s4_rst_owd", owd_a, 1'b0);
    check("s4_rst_we", we_a, 1'b0);
    check("s4_rst_cs", cs_a, 1'b0);
    check("s4_rst_ovf_b", ovf_b, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ows_a || owd_a || we_a || cs_a || ows_b || owd_b || st_a != 2'd0) bad = 1'b1;
    end
    check("s4_quiet_after_rst", bad, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
